fifo2_rr_scheduler: RTL and testbench
=====================================

// Module: fifo2_rr_scheduler
// PURPOSE
//  Round-robin scheduler that drains NREQ upstream depth-2 FIFOs into one downstream FIFO.
//  - Upstream side uses the EMPTY_N/DEQ interface; downstream side uses the FULL_N/ENQ interface.
//  - A grant is held for up to QUANTUM beats. It then rotates with no bubble when another source waits.
//  - Data path is a pure mux: zero-cycle transfer once a grant is registered.
// PARAMETERS
//  WIDTH    8  data width per source and sink
//  NREQ     4  number of upstream FIFOs, >=2
//  QUANTUM  4  max beats per grant before rotation, >=1
// PORTS
//  CLK          in   1           clock, rising edge
//  RST          in   1           reset, synchronous, active-high
//  CLR          in   1           sync clear of scheduler state (not data)
//  SRC_D_OUT    in   NREQ*WIDTH  source heads; slice i = [i*WIDTH +: WIDTH]
//  SRC_EMPTY_N  in   NREQ        source i holds >=1 entry
//  SRC_DEQ      out  NREQ        dequeue strobe, one-hot or zero
//  DST_D_IN     out  WIDTH       = slice GRANT_IDX of SRC_D_OUT
//  DST_ENQ      out  1           enqueue strobe to sink
//  DST_FULL_N   in   1           sink can accept
//  GRANT_VLD    out  1           registered: a source is granted
//  GRANT_IDX    out  IDXW        registered granted index; IDXW = $clog2(NREQ)
// BEHAVIOUR
//  - Reset (RST=1 at edge): state=IDLE, ptr=0, cnt=0, GRANT_VLD=0, GRANT_IDX=0.
//    SRC_DEQ and DST_ENQ are forced 0 while RST or CLR is high.
//  - fire = (state==HOLD) & SRC_EMPTY_N[g] & DST_FULL_N & !RST & !CLR, where g = GRANT_IDX.
//    DST_ENQ = fire; SRC_DEQ = fire << g. Never ENQ into a full sink; never DEQ from an empty source.
//  - pick(start) returns the first i with SRC_EMPTY_N[i]=1, searching start, start+1, ..., mod NREQ.
//  - IDLE: if any SRC_EMPTY_N, register g=pick(ptr), cnt=0, go to HOLD. Else stay.
//    Latency from first EMPTY_N=1 to first possible DST_ENQ is 1 cycle.
//  - HOLD, release conditions, evaluated each cycle:
//    (a) SRC_EMPTY_N[g]=0: release with no transfer.
//    (b) fire and cnt==QUANTUM-1: release after this beat.
//  - HOLD, otherwise:
//    - fire: cnt++.
//    - DST_FULL_N=0: stall; cnt, g and state hold.
//  - On release: ptr <= g+1 (wraps at NREQ).
//    - If any SRC_EMPTY_N, then g <= pick(g+1), cnt <= 0, stay in HOLD. This is a no-bubble switch.
//      The released source may be re-picked last if it is the only one still non-empty.
//    - Otherwise go to IDLE, GRANT_VLD <= 0.
//  - cnt width is $clog2(QUANTUM)+1. With QUANTUM=1, every fire releases.
//  - CLR=1 has the same effect as reset on state, ptr, cnt and grant. No transfer occurs in the CLR cycle.
//    RST or CLR mid-HOLD abandons the grant. The source keeps its data; nothing is lost or duplicated.
//  - ptr advances only on release, never on stall.
//    Starvation bound: a waiting source is served within (NREQ-1)*QUANTUM beats.
//  - Checks (translate_off): SRC_DEQ not one-hot-or-zero -> error; fire with DST_FULL_N=0 -> error.
// STRUCTURE
//  - Package fifo2_sched_pkg holds:
//    - typedef sched_state_t {IDLE, HOLD};
//    - function idx_w(n) = (n>1) ? $clog2(n) : 1.
//  - Sub-module rr_pick #(N): inputs req[N] and start; outputs any and idx (rotate, priority-encode, unrotate).
//    It is instantiated twice: pick(ptr) and pick(g+1).
//  - Top holds the state register, cnt/ptr/grant registers, the fire logic and the WIDTH mux.
// TESTING
//  T1 Reset: hold RST=1 2 cycles with all EMPTY_N=1.
//     -> GRANT_VLD=0, DST_ENQ=0, SRC_DEQ=0.
//     First cycle after RST=0: GRANT_VLD=1, IDX=0.
//  T2 Single source 2 with 6 items, QUANTUM=4, sink always ready.
//     -> Grant 2 at t+1; ENQ on 4 beats; re-grant 2 with no bubble; 2 beats; empty-release to IDLE.
//  T3 All 4 sources continuously non-empty.
//     -> Grant order 0,1,2,3,0; 4 beats each; DST_D_IN equals the granted slice every beat; ENQ every cycle.
//  T4 Backpressure: DST_FULL_N=0 for 3 cycles at cnt=2.
//     -> No ENQ/DEQ; cnt=2 and g held. Resume: exactly 2 more beats, then rotate.
//  T5 CLR for 1 cycle during HOLD with g=1, cnt=2.
//     -> No transfer that cycle; next cycle IDLE, ptr=0; then re-grant from pick(0).
//  T6 Source 3 drains mid-quantum: EMPTY_N[3]=0 at cnt=1 while source 0 waits.
//     -> Same-cycle rotation to g=0; ptr=0 (wrap from 3+1); no ENQ in the release cycle.

Source files
------------

// File: rtl/fifo2_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo2_sched_pkg
// Brief  : Shared types and helpers for the FIFO2 round-robin scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package fifo2_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    // Index width that stays legal (>=1 bit) even for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo2_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Rotating priority pick: first asserted req at or after start, mod N.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick
    import fifo2_sched_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = idx_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    int              pos;
    logic [IDXW-1:0] pos_i;

    assign any = |req;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx   = '0;
        pos   = 0;
        pos_i = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos   = (int'(start) + k) % N;
            pos_i = IDXW'(pos);
            if (req[pos_i]) begin
                idx = pos_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo2_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : fifo2_rr_scheduler
// Brief  : Round-robin drain of NREQ depth-2 FIFOs into one sink FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module fifo2_rr_scheduler
    import fifo2_sched_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int QUANTUM = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CLR,
    input  logic [NREQ*WIDTH-1:0]     SRC_D_OUT,
    input  logic [NREQ-1:0]           SRC_EMPTY_N,
    output logic [NREQ-1:0]           SRC_DEQ,
    output logic [WIDTH-1:0]          DST_D_IN,
    output logic                      DST_ENQ,
    input  logic                      DST_FULL_N,
    output logic                      GRANT_VLD,
    output logic [idx_w(NREQ)-1:0]    GRANT_IDX
);

    localparam int                IDXW     = idx_w(NREQ);
    localparam int                CNTW     = $clog2(QUANTUM) + 1;
    localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(QUANTUM - 1);
    localparam logic [IDXW-1:0]   IDX_MAX  = IDXW'(NREQ - 1);

    sched_state_t    state;
    sched_state_t    state_next;
    logic [IDXW-1:0] ptr;
    logic [CNTW-1:0] cnt;
    logic [IDXW-1:0] grant_idx;
    logic            grant_vld;

    logic [IDXW-1:0] g_next;
    logic            head_valid;
    logic            fire;
    logic            release_now;
    logic            ptr_any;
    logic [IDXW-1:0] ptr_idx;
    logic            nxt_any;
    logic [IDXW-1:0] nxt_idx;

    rr_pick #(.N(NREQ), .IDXW(IDXW)) u_pick_ptr (
        .req   (SRC_EMPTY_N),
        .start (ptr),
        .any   (ptr_any),
        .idx   (ptr_idx)
    );

    rr_pick #(.N(NREQ), .IDXW(IDXW)) u_pick_next (
        .req   (SRC_EMPTY_N),
        .start (g_next),
        .any   (nxt_any),
        .idx   (nxt_idx)
    );

    assign g_next      = (grant_idx == IDX_MAX) ? '0 : grant_idx + 1'b1;
    assign head_valid  = SRC_EMPTY_N[grant_idx];
    assign fire        = (state == HOLD) & head_valid & DST_FULL_N & ~RST & ~CLR;
    // Release on an empty head, or after the final beat of the quantum.
    assign release_now = (state == HOLD) & (~head_valid | (fire & (cnt == CNT_LAST)));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ptr_any) state_next = HOLD;
            HOLD:    if (release_now && !nxt_any) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            ptr       <= '0;
            cnt       <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
        end else if (state == IDLE) begin
            if (ptr_any) begin
                grant_idx <= ptr_idx;
                cnt       <= '0;
                grant_vld <= 1'b1;
            end
        end else if (release_now) begin
            ptr <= g_next;
            cnt <= '0;
            if (nxt_any) begin
                grant_idx <= nxt_idx;
            end else begin
                grant_vld <= 1'b0;
            end
        end else if (fire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign DST_ENQ   = fire;
    assign SRC_DEQ   = {{(NREQ-1){1'b0}}, fire} << grant_idx;
    assign DST_D_IN  = SRC_D_OUT[grant_idx*WIDTH +: WIDTH];
    assign GRANT_VLD = grant_vld;
    assign GRANT_IDX = grant_idx;

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert ($onehot0(SRC_DEQ))
                else $error("SRC_DEQ not one-hot-or-zero: %b", SRC_DEQ);
            assert (!(fire && !DST_FULL_N))
                else $error("enqueue into full sink");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo2_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo2_rr_scheduler
// Brief  : Scoreboard bench for fifo2_rr_scheduler with queue-modelled sources.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fifo2_rr_scheduler;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  CLR = 1'b0;
    logic [NREQ*WIDTH-1:0] SRC_D_OUT = '0;
    logic [NREQ-1:0]       SRC_EMPTY_N = '0;
    logic [NREQ-1:0]       SRC_DEQ;
    logic [WIDTH-1:0]      DST_D_IN;
    logic                  DST_ENQ;
    logic                  DST_FULL_N = 1'b1;
    logic                  GRANT_VLD;
    logic [1:0]            GRANT_IDX;

    fifo2_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .QUANTUM(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .CLR         (CLR),
        .SRC_D_OUT   (SRC_D_OUT),
        .SRC_EMPTY_N (SRC_EMPTY_N),
        .SRC_DEQ     (SRC_DEQ),
        .DST_D_IN    (DST_D_IN),
        .DST_ENQ     (DST_ENQ),
        .DST_FULL_N  (DST_FULL_N),
        .GRANT_VLD   (GRANT_VLD),
        .GRANT_IDX   (GRANT_IDX)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    logic [7:0] srcq [NREQ][$];
    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    logic       rst_plan  = 1'b1;
    logic       clr_plan  = 1'b0;
    logic       full_plan = 1'b1;

    function automatic logic [7:0] dv(input int s, input int k);
        return 8'(s * 64 + k);
    endfunction

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) srcq[s].push_back(dv(s, k));
    endtask

    task automatic expect_item(input int s, input int k);
        exp_t e;
        e.src  = s;
        e.data = dv(s, k);
        exp_q.push_back(e);
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NREQ; i++) begin
            SRC_EMPTY_N[i]          = (srcq[i].size() > 0);
            SRC_D_OUT[i*WIDTH +: WIDTH] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
        end
    endtask

    // Called at a falling edge: score the current beat, then advance one cycle.
    task automatic tick();
        exp_t            e;
        logic [NREQ-1:0] deq_s;
        checks++;
        if (DST_ENQ === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL enq_unexpected: got data %h deq %b, none expected", DST_D_IN, SRC_DEQ);
            end else begin
                e = exp_q.pop_front();
                if (DST_D_IN !== e.data || SRC_DEQ !== NREQ'(1 << e.src)) begin
                    errors++;
                    $display("FAIL beat: got data %h deq %b, want data %h deq %b",
                             DST_D_IN, SRC_DEQ, e.data, NREQ'(1 << e.src));
                end
            end
        end else if (SRC_DEQ !== '0) begin
            errors++;
            $display("FAIL deq_without_enq: got deq %b, want 0000", SRC_DEQ);
        end
        deq_s = SRC_DEQ;
        @(posedge CLK);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (deq_s[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        RST        = rst_plan;
        CLR        = clr_plan;
        DST_FULL_N = full_plan;
        drive_srcs();
        @(negedge CLK);
    endtask

    task automatic reset_phase();
        rst_plan  = 1'b1;
        clr_plan  = 1'b0;
        full_plan = 1'b1;
        tick();
        for (int i = 0; i < NREQ; i++) srcq[i].delete();
        exp_q.delete();
        drive_srcs();
    endtask

    task automatic start_run();
        drive_srcs();
        rst_plan = 1'b0;
        tick();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding after %0d cycles, want 0",
                     name, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        reset_phase();
        for (int s = 0; s < NREQ; s++) begin
            load(s, 1);
            expect_item(s, 0);
        end
        drive_srcs();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (GRANT_VLD !== 1'b0 || DST_ENQ !== 1'b0 || SRC_DEQ !== '0) begin
                errors++;
                $display("FAIL reset_hold: got vld %b enq %b deq %b, want 0 0 0000",
                         GRANT_VLD, DST_ENQ, SRC_DEQ);
            end
            tick();
        end
        start_run();
        checks++;
        if (GRANT_VLD !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got vld %b, want 0", GRANT_VLD);
        end
        tick();
        checks++;
        if (GRANT_VLD !== 1'b1 || GRANT_IDX !== 2'd0 || DST_ENQ !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got vld %b idx %0d enq %b, want 1 0 1",
                     GRANT_VLD, GRANT_IDX, DST_ENQ);
        end
        drain("reset", 40);
    endtask

    task automatic test_single_source();
        logic [8:0] e_enq = 9'b001111110;
        logic [8:0] e_vld = 9'b011111110;
        reset_phase();
        load(2, 6);
        for (int k = 0; k < 6; k++) expect_item(2, k);
        start_run();
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (DST_ENQ !== e_enq[n] || GRANT_VLD !== e_vld[n]) begin
                errors++;
                $display("FAIL single_n%0d: got enq %b vld %b, want %b %b",
                         n, DST_ENQ, GRANT_VLD, e_enq[n], e_vld[n]);
            end
            if (e_vld[n]) begin
                checks++;
                if (GRANT_IDX !== 2'd2) begin
                    errors++;
                    $display("FAIL single_idx_n%0d: got %0d, want 2", n, GRANT_IDX);
                end
            end
            tick();
        end
        drain("single", 20);
    endtask

    task automatic test_back_to_back();
        reset_phase();
        for (int s = 0; s < NREQ; s++) load(s, 8);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NREQ; s++)
                for (int k = r * 4; k < r * 4 + 4; k++) expect_item(s, k);
        start_run();
        tick();
        for (int n = 1; n <= 20; n++) begin
            checks++;
            if (DST_ENQ !== 1'b1 || GRANT_IDX !== 2'(((n - 1) / 4) % 4)) begin
                errors++;
                $display("FAIL b2b_n%0d: got enq %b idx %0d, want 1 %0d",
                         n, DST_ENQ, GRANT_IDX, ((n - 1) / 4) % 4);
            end
            tick();
        end
        drain("b2b", 60);
    endtask

    task automatic test_backpressure();
        logic [8:0] e_enq = 9'b111000110;
        reset_phase();
        load(1, 6);
        load(2, 2);
        for (int k = 0; k < 4; k++) expect_item(1, k);
        expect_item(2, 0);
        expect_item(2, 1);
        expect_item(1, 4);
        expect_item(1, 5);
        start_run();
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (DST_ENQ !== e_enq[n]) begin
                errors++;
                $display("FAIL bp_enq_n%0d: got %b, want %b", n, DST_ENQ, e_enq[n]);
            end
            if (n >= 3 && n <= 5) begin
                checks++;
                if (GRANT_IDX !== 2'd1 || GRANT_VLD !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold_n%0d: got idx %0d vld %b, want 1 1", n, GRANT_IDX, GRANT_VLD);
                end
            end
            if (n == 8) begin
                checks++;
                if (GRANT_IDX !== 2'd2) begin
                    errors++;
                    $display("FAIL bp_rotate: got idx %0d, want 2", GRANT_IDX);
                end
            end
            if (n == 2) full_plan = 1'b0;
            if (n == 5) full_plan = 1'b1;
            tick();
        end
        drain("bp", 30);
    endtask

    task automatic test_clear();
        reset_phase();
        load(0, 1);
        load(1, 6);
        load(2, 2);
        expect_item(0, 0);
        expect_item(1, 0);
        expect_item(1, 1);
        expect_item(0, 1);
        for (int k = 2; k < 6; k++) expect_item(1, k);
        expect_item(2, 0);
        expect_item(2, 1);
        start_run();
        for (int n = 0; n < 8; n++) begin
            if (n == 3) begin
                checks++;
                if (GRANT_IDX !== 2'd1 || DST_ENQ !== 1'b1) begin
                    errors++;
                    $display("FAIL clr_pre: got idx %0d enq %b, want 1 1", GRANT_IDX, DST_ENQ);
                end
            end
            if (n == 5) begin
                checks++;
                if (DST_ENQ !== 1'b0 || SRC_DEQ !== '0) begin
                    errors++;
                    $display("FAIL clr_cycle: got enq %b deq %b, want 0 0000", DST_ENQ, SRC_DEQ);
                end
                clr_plan = 1'b0;
            end
            if (n == 6) begin
                checks++;
                if (GRANT_VLD !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_idle: got vld %b, want 0", GRANT_VLD);
                end
            end
            if (n == 7) begin
                checks++;
                if (GRANT_VLD !== 1'b1 || GRANT_IDX !== 2'd0) begin
                    errors++;
                    $display("FAIL clr_regrant: got vld %b idx %0d, want 1 0", GRANT_VLD, GRANT_IDX);
                end
            end
            if (n == 4) begin
                clr_plan = 1'b1;
                srcq[0].push_back(dv(0, 1));
            end
            tick();
        end
        drain("clr", 30);
    endtask

    task automatic test_drain_rotate();
        reset_phase();
        load(3, 1);
        expect_item(3, 0);
        expect_item(0, 0);
        start_run();
        tick();
        checks++;
        if (GRANT_IDX !== 2'd3 || DST_ENQ !== 1'b1) begin
            errors++;
            $display("FAIL drain_first: got idx %0d enq %b, want 3 1", GRANT_IDX, DST_ENQ);
        end
        srcq[0].push_back(dv(0, 0));
        tick();
        checks++;
        if (DST_ENQ !== 1'b0 || GRANT_VLD !== 1'b1 || GRANT_IDX !== 2'd3) begin
            errors++;
            $display("FAIL drain_release: got enq %b vld %b idx %0d, want 0 1 3",
                     DST_ENQ, GRANT_VLD, GRANT_IDX);
        end
        tick();
        checks++;
        if (DST_ENQ !== 1'b1 || GRANT_IDX !== 2'd0) begin
            errors++;
            $display("FAIL drain_wrap: got enq %b idx %0d, want 1 0", DST_ENQ, GRANT_IDX);
        end
        drain("drain", 10);
    endtask

    initial begin
        drive_srcs();
        @(negedge CLK);
        test_reset();
        test_single_source();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_drain_rotate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
